// File: rtl/shift_add_mult.sv
// shift_add_mult: sequential unsigned W x W -> 2W shift-and-add multiplier.
// A rising edge on start (seen while idle) loads the operands; one partial
// product is folded into the accumulator per RUN cycle, and the result is
// published on product together with a one-cycle done pulse.
// Optional feature: define SHIFT_ADD_MULT_EARLY_TERM_EN to leave RUN as soon
// as the remaining multiplier bits are all zero.
module shift_add_mult #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] product,
    output logic           done,
    output logic           busy
);

    // One extra bit so the counter can reach W without wrapping.
    localparam int CW = $clog2(W) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic           start_q, start_d;
    logic [2*W-1:0] mcand_q, mcand_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [2*W-1:0] product_q, product_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           done_q, done_d;
    logic           busy_q, busy_d;

    logic           accept;
    logic           last_iter;
    logic [2*W-1:0] acc_sum;
    logic [W-1:0]   mplier_shr;

    // Next-state, datapath step and registered status outputs.
    always_comb begin
        state_d    = state_q;
        start_d    = start;
        mcand_d    = mcand_q;
        acc_d      = acc_q;
        product_d  = product_q;
        mplier_d   = mplier_q;
        cnt_d      = cnt_q;
        accept     = start & ~start_q & (state_q == IDLE);
        acc_sum    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mplier_shr = mplier_q >> 1;
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
        // Once no multiplier bits remain, later iterations add nothing.
        last_iter  = (cnt_q == CW'(W - 1)) || (mplier_shr == '0);
`else
        last_iter  = (cnt_q == CW'(W - 1));
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    mcand_d  = {{W{1'b0}}, a};
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_shr;
                cnt_d    = cnt_q + CW'(1);
                if (last_iter) begin
                    product_d = acc_sum;
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    // State registers; start_q resets high so a start held through reset
    // must drop before it can be accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            start_q   <= 1'b1;
            mcand_q   <= '0;
            acc_q     <= '0;
            product_q <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign product = product_q;
    assign done    = done_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// tb_shift_add_mult: table-driven and randomized checks of shift_add_mult
// (W=4) against an arithmetic reference model; follows
// SHIFT_ADD_MULT_EARLY_TERM_EN for the expected RUN length.
module tb_shift_add_mult;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic [2*W-1:0] product;
    logic           done;
    logic           busy;

    int tests = 0;
    int fails = 0;
    logic [2*W-1:0] exp_prev = '0;

    shift_add_mult #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .product(product), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
        int             cyc_full;
        int             cyc_early;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference RUN length: W cycles, or with early termination the number
    // of significant bits in b (at least one).
    function automatic int model_cycles(input logic [W-1:0] bb);
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
        int n = 1;
        for (int i = 0; i < W; i++) if (bb[i]) n = i + 1;
        return n;
`else
        return W;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation from idle: a one-cycle start pulse, then latency,
    // product-hold, busy and single-cycle done checks.
    task automatic run_op(input logic [W-1:0] aa, input logic [W-1:0] bb,
                          input logic [2*W-1:0] ep, input int ecyc, input string nm);
        int n;
        start = 1'b0;
        tick();
        a = aa; b = bb; start = 1'b1;
        tick();
        start = 1'b0;
        check({nm, " busy_after_accept"}, int'(busy), 1);
        n = 0;
        while (!done && n < 20) begin
            check({nm, " product_hold"}, int'(product), int'(exp_prev));
            tick();
            n++;
        end
        check({nm, " latency"}, n, ecyc);
        check({nm, " product"}, int'(product), int'(ep));
        check({nm, " busy_in_done"}, int'(busy), 1);
        tick();
        check({nm, " done_pulse"}, int'(done), 0);
        check({nm, " busy_end"}, int'(busy), 0);
        exp_prev = ep;
    endtask

    initial begin
        int ndone;
        logic [W-1:0] ra, rb;

        vecs[0] = '{4'd5,  4'd3,  8'd15,  4, 2};
        vecs[1] = '{4'd15, 4'd15, 8'hE1,  4, 4};
        vecs[2] = '{4'd0,  4'd15, 8'd0,   4, 4};
        vecs[3] = '{4'd7,  4'd0,  8'd0,   4, 1};
        vecs[4] = '{4'd3,  4'd2,  8'd6,   4, 2};
        vecs[5] = '{4'd6,  4'd4,  8'd24,  4, 3};
        vecs[6] = '{4'd1,  4'd1,  8'd1,   4, 1};
        vecs[7] = '{4'd12, 4'd9,  8'd108, 4, 4};

        // Reset state
        #2;
        check("reset_product", int'(product), 0);
        check("reset_done", int'(done), 0);
        check("reset_busy", int'(busy), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Directed table
        for (int i = 0; i < 8; i++) begin
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
            run_op(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].cyc_early, $sformatf("vec%0d", i));
`else
            run_op(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].cyc_full, $sformatf("vec%0d", i));
`endif
        end

        // Start held high for 10 cycles: exactly one result
        start = 1'b0;
        tick();
        a = 4'd6; b = 4'd7; start = 1'b1;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) ndone++;
        end
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done) ndone++;
        end
        check("held_start_done_count", ndone, 1);
        check("held_start_product", int'(product), 42);
        check("held_start_idle", int'(busy), 0);
        exp_prev = 8'd42;
        run_op(4'd2, 4'd3, 8'd6, model_cycles(4'd3), "after_held");

        // Reset mid-operation, with start held through reset release
        a = 4'd9; b = 4'd9; start = 1'b1;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("abort_product", int'(product), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        tick();
        tick();
        rst_n = 1'b1;
        exp_prev = '0;
        ndone = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (busy || done) ndone++;
        end
        check("no_accept_after_reset", ndone, 0);
        run_op(4'd9, 4'd9, 8'd81, model_cycles(4'd9), "after_reset");

        // Randomized operands against the arithmetic model
        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom_range(0, 15));
            rb = W'($urandom_range(0, 15));
            run_op(ra, rb, 8'(ra * rb), model_cycles(rb), $sformatf("rand%0d", i));
        end

        // Exhaustive sweep
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                run_op(W'(ia), W'(ib), 8'(ia * ib), model_cycles(W'(ib)),
                       $sformatf("sweep_%0d_%0d", ia, ib));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
